// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the EX-stage branch resolver and BHT.
// Funct3 branch codes, 2-bit counter states, redirect select codes.
package branch_predict_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] RED_NONE   = 2'b00;
  localparam logic [1:0] RED_TARGET = 2'b01;
  localparam logic [1:0] RED_SEQ    = 2'b10;

endpackage

// File: rtl/branch_predict_unit_comparator.sv
// Combinational RV32I branch condition evaluation.
// Reserved funct3 codes resolve not-taken and flag illegal.
module branch_comparator
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lts;
  logic ltu;

  assign eq  = (rs1 == rs2);
  assign lts = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lts;
      F3_BGE:  taken = ~lts;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a 2-bit BHT predictor,
// mispredict redirect selection and saturating perf counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_STATE  = 2'b01,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  IF_PC_i,
  output logic             Predict_Taken_o,
  input  logic             EX_Valid_i,
  input  logic             EX_Branch_i,
  input  logic             EX_Stall_i,
  input  logic [XLEN-1:0]  EX_PC_i,
  input  logic [2:0]       EX_Funct3_i,
  input  logic [XLEN-1:0]  EX_Rs1_i,
  input  logic [XLEN-1:0]  EX_Rs2_i,
  input  logic             EX_Pred_Taken_i,
  input  logic             Clear_Counters_i,
  output logic             Branch_Taken_o,
  output logic             Mispredict_o,
  output logic [1:0]       Redirect_Sel_o,
  output logic             Illegal_Branch_o,
  output logic [CNT_W-1:0] Branch_Count_o,
  output logic [CNT_W-1:0] Mispredict_Count_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             res;
  logic             cmp_taken;
  logic             cmp_illegal;
  logic             legal;
  logic [1:0]       cur;
  logic             unused_pc;

  assign if_idx = IF_PC_i[IDX_W+1:2];
  assign ex_idx = EX_PC_i[IDX_W+1:2];
  assign unused_pc = &{1'b0, IF_PC_i[XLEN-1:IDX_W+2], IF_PC_i[1:0],
                       EX_PC_i[XLEN-1:IDX_W+2], EX_PC_i[1:0]};

  branch_comparator #(.XLEN(XLEN)) u_cmp (
    .funct3  (EX_Funct3_i),
    .rs1     (EX_Rs1_i),
    .rs2     (EX_Rs2_i),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign res              = EX_Valid_i & EX_Branch_i & ~EX_Stall_i;
  assign legal            = res & ~cmp_illegal;
  assign Branch_Taken_o   = res & cmp_taken;
  assign Illegal_Branch_o = res & cmp_illegal;
  assign Mispredict_o     = res & (Branch_Taken_o != EX_Pred_Taken_i);
  assign Predict_Taken_o  = bht[if_idx][1];
  assign cur              = bht[ex_idx];

  always_comb begin
    Redirect_Sel_o = RED_NONE;
    if (Mispredict_o)
      Redirect_Sel_o = Branch_Taken_o ? RED_TARGET : RED_SEQ;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= INIT_STATE;
    end else if (legal) begin
      if (Branch_Taken_o && cur != ST)
        bht[ex_idx] <= cur + 2'd1;
      else if (!Branch_Taken_o && cur != SNT)
        bht[ex_idx] <= cur - 2'd1;
    end
  end

  // Clear wins over increment; both saturate at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Branch_Count_o     <= '0;
      Mispredict_Count_o <= '0;
    end else if (Clear_Counters_i) begin
      Branch_Count_o     <= '0;
      Mispredict_Count_o <= '0;
    end else begin
      if (legal && !(&Branch_Count_o))
        Branch_Count_o <= Branch_Count_o + 1'b1;
      if (Mispredict_o && !(&Mispredict_Count_o))
        Mispredict_Count_o <= Mispredict_Count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit.
// Hand-computed expectations checked with immediate assertions.
module tb_branch_predict_unit;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_o;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [2:0]  ex_f3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic        ex_pred;
  logic        clr;
  logic        taken_o;
  logic        misp_o;
  logic [1:0]  red_o;
  logic        ill_o;
  logic [31:0] bcnt_o;
  logic [31:0] mcnt_o;

  int checks = 0;
  int errors = 0;

  branch_predict_unit dut (
    .clk                (clk),
    .reset              (reset),
    .IF_PC_i            (if_pc),
    .Predict_Taken_o    (pred_o),
    .EX_Valid_i         (ex_valid),
    .EX_Branch_i        (ex_branch),
    .EX_Stall_i         (ex_stall),
    .EX_PC_i            (ex_pc),
    .EX_Funct3_i        (ex_f3),
    .EX_Rs1_i           (ex_rs1),
    .EX_Rs2_i           (ex_rs2),
    .EX_Pred_Taken_i    (ex_pred),
    .Clear_Counters_i   (clr),
    .Branch_Taken_o     (taken_o),
    .Mispredict_o       (misp_o),
    .Redirect_Sel_o     (red_o),
    .Illegal_Branch_o   (ill_o),
    .Branch_Count_o     (bcnt_o),
    .Mispredict_Count_o (mcnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic p);
    ex_valid  = 1'b1;
    ex_branch = 1'b1;
    ex_pc     = pc;
    ex_f3     = f3;
    ex_rs1    = a;
    ex_rs2    = b;
    ex_pred   = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
    clr       = 1'b0;
    #1;
  endtask

  task automatic br(input logic [31:0] pc, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic p);
    drive(pc, f3, a, b, p);
    tick();
  endtask

  initial begin
    reset = 1'b0; if_pc = 32'h100; ex_valid = 0; ex_branch = 0;
    ex_stall = 0; ex_pc = 0; ex_f3 = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_pred = 0; clr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_pred", pred_o, 0);
    chk("rst_bcnt", bcnt_o, 0);
    chk("rst_mcnt", mcnt_o, 0);
    chk("idle_red", red_o, 0);

    // BEQ taken, predicted not-taken
    drive(32'h100, 3'b000, 5, 5, 0);
    chk("beq_taken", taken_o, 1);
    chk("beq_misp", misp_o, 1);
    chk("beq_red", red_o, 2'b01);
    chk("beq_nobypass", pred_o, 0);
    tick();
    chk("beq_pred", pred_o, 1);
    chk("beq_bcnt", bcnt_o, 1);
    chk("beq_mcnt", mcnt_o, 1);

    // signed vs unsigned, combinational only
    drive(32'h300, 3'b100, 32'hFFFFFFFF, 1, 0);
    chk("blt", taken_o, 1);
    drive(32'h300, 3'b101, 32'hFFFFFFFF, 1, 0);
    chk("bge", taken_o, 0);
    drive(32'h300, 3'b110, 32'hFFFFFFFF, 1, 0);
    chk("bltu", taken_o, 0);
    drive(32'h300, 3'b111, 32'hFFFFFFFF, 1, 0);
    chk("bgeu", taken_o, 1);
    drive(32'h300, 3'b001, 7, 7, 0);
    chk("bne_eq", taken_o, 0);
    ex_valid = 0; ex_branch = 0; #1;
    chk("res0_taken", taken_o, 0);

    // saturation at 11, then back down
    repeat (4) br(32'h100, 3'b000, 5, 5, 1);
    chk("sat_hi_pred", pred_o, 1);
    chk("sat_hi_bcnt", bcnt_o, 5);
    chk("sat_hi_mcnt", mcnt_o, 1);
    drive(32'h100, 3'b000, 5, 6, 1);
    chk("nt_red", red_o, 2'b10);
    tick();
    chk("wt_pred", pred_o, 1);
    if_pc = 32'h200; #1;
    chk("alias_pred", pred_o, 1);
    if_pc = 32'h100;
    repeat (3) br(32'h100, 3'b000, 5, 6, 0);
    chk("snt_pred", pred_o, 0);
    br(32'h100, 3'b000, 5, 6, 0);
    chk("sat_lo_pred", pred_o, 0);
    chk("sat_lo_bcnt", bcnt_o, 10);
    chk("sat_lo_mcnt", mcnt_o, 2);
    br(32'h100, 3'b000, 5, 5, 0);
    chk("up1_pred", pred_o, 0);
    br(32'h100, 3'b000, 5, 5, 0);
    chk("up2_pred", pred_o, 1);
    chk("up2_bcnt", bcnt_o, 12);
    chk("up2_mcnt", mcnt_o, 4);

    // stalled BNE, resolved once on release
    if_pc = 32'h104;
    ex_stall = 1'b1;
    drive(32'h104, 3'b001, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_taken", taken_o, 0);
      chk("stall_misp", misp_o, 0);
      @(posedge clk);
      #1;
    end
    chk("stall_red", red_o, 0);
    chk("stall_bcnt", bcnt_o, 12);
    chk("stall_pred", pred_o, 0);
    ex_stall = 1'b0; #1;
    chk("rel_misp", misp_o, 1);
    tick();
    chk("rel_bcnt", bcnt_o, 13);
    chk("rel_mcnt", mcnt_o, 5);
    chk("rel_pred", pred_o, 1);
    @(posedge clk); #1;
    chk("once_bcnt", bcnt_o, 13);

    // illegal funct3
    drive(32'h104, 3'b010, 1, 2, 1);
    chk("ill_flag", ill_o, 1);
    chk("ill_misp", misp_o, 1);
    chk("ill_red", red_o, 2'b10);
    tick();
    chk("ill_pred", pred_o, 1);
    chk("ill_bcnt", bcnt_o, 13);
    chk("ill_mcnt", mcnt_o, 6);

    // clear collides with a mispredict
    if_pc = 32'h108;
    clr = 1'b1;
    br(32'h108, 3'b000, 9, 9, 0);
    chk("clr_bcnt", bcnt_o, 0);
    chk("clr_mcnt", mcnt_o, 0);
    chk("clr_bht", pred_o, 1);
    br(32'h108, 3'b000, 9, 9, 0);
    chk("post_clr_bcnt", bcnt_o, 1);

    // asynchronous reset mid-cycle
    if_pc = 32'h104;
    #2 reset = 1'b0;
    #1;
    chk("arst_pred", pred_o, 0);
    chk("arst_bcnt", bcnt_o, 0);
    chk("arst_mcnt", mcnt_o, 0);
    drive(32'h104, 3'b000, 3, 3, 1);
    chk("arst_comb", taken_o, 1);
    tick();
    reset = 1'b1; #1;
    chk("arst_noupd", pred_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Successor to the control unit's single Zero-flag branch resolution. It resolves all six RV32I conditional branches directly from operand values in EX. It adds a parametrised branch history table (BHT) of 2-bit saturating counters, which IF reads to predict direction. It detects mispredictions, selects the redirect source, and keeps saturating performance counters.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of BHT entries; power of two, >= 2; IDX_W = log2(BHT_ENTRIES)
INIT_STATE, 2'b01, reset value of every BHT counter (weakly not-taken)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low
IF_PC_i  input  XLEN  fetch PC for lookup
Predict_Taken_o  output  1  prediction for IF_PC_i; combinational, equals BHT[IF_PC_i[IDX_W+1:2]][1]
EX_Valid_i  input  1  EX stage holds a valid instruction
EX_Branch_i  input  1  EX instruction is a conditional branch
EX_Stall_i  input  1  EX stage is held this cycle
EX_PC_i  input  XLEN  PC of the EX instruction
EX_Funct3_i  input  3  branch condition
EX_Rs1_i  input  XLEN  operand 1
EX_Rs2_i  input  XLEN  operand 2
EX_Pred_Taken_i  input  1  prediction carried down the pipe with the instruction
Clear_Counters_i  input  1  synchronous clear of the performance counters
Branch_Taken_o  output  1  actual branch outcome
Mispredict_o  output  1  actual outcome differs from EX_Pred_Taken_i
Redirect_Sel_o  output  2  00 no redirect, 01 branch target, 10 EX_PC_i+4
Illegal_Branch_o  output  1  funct3 is 010 or 011 on a valid branch
Branch_Count_o  output  CNT_W  number of resolved legal branches
Mispredict_Count_o  output  CNT_W  number of resolved mispredictions, including illegal ones

Behaviour:
- Resolve condition: res = EX_Valid_i & EX_Branch_i & !EX_Stall_i. While res=0, Branch_Taken_o, Mispredict_o and Illegal_Branch_o are 0 and Redirect_Sel_o=00.
- Comparison by funct3:
  - 000 BEQ: taken if rs1 == rs2.
  - 001 BNE: taken if rs1 != rs2.
  - 100 BLT: signed less-than.
  - 101 BGE: signed greater-or-equal.
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: unsigned greater-or-equal.
  - 010/011: not taken, Illegal_Branch_o=1.
- Branch_Taken_o, Mispredict_o, Redirect_Sel_o and Illegal_Branch_o are combinational in the same cycle, with zero latency.
- Mispredict_o = res & (Branch_Taken_o != EX_Pred_Taken_i).
- Redirect_Sel_o = 01 when mispredicted and actually taken; 10 when mispredicted and actually not taken; otherwise 00.
- BHT index is PC[IDX_W+1:2]. Aliasing is permitted; there are no tags.
- BHT update on the rising edge when res & legal funct3:
  - Taken: counter +1, saturating at 11.
  - Not taken: counter -1, saturating at 00.
  - States: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Illegal funct3 produces no BHT update.
- Lookup and update at the same index in the same cycle: Predict_Taken_o shows the pre-update value; there is no bypass. The new value is visible from the next cycle.
- Branch_Count_o increments when res & legal. Mispredict_Count_o increments when Mispredict_o.
- Both counters saturate at all-ones and never wrap.
- Clear_Counters_i has priority over increment in the same cycle: counter becomes 0. It does not affect the BHT.
- Reset (async assert, at any time including mid-update): all BHT entries = INIT_STATE and both counters = 0, immediately. Combinational outputs follow their inputs and the reset state. No update occurs while reset=0.
- A stalled branch is resolved exactly once, in the first cycle EX_Stall_i=0.

Decomposition:
- Shared package holds:
  - funct3 branch encodings (BEQ..BGEU).
  - 2-bit counter state constants (SNT, WNT, WT, ST).
  - Redirect_Sel encodings (RED_NONE=00, RED_TARGET=01, RED_SEQ=10).
- One natural sub-module: branch_comparator, purely combinational. Inputs are funct3, rs1 and rs2; outputs are taken and illegal.
- BHT storage and counters stay in branch_predict_unit.

Test Plan:
- Reset: hold reset=0, release; any IF_PC_i -> Predict_Taken_o=0, Branch_Count_o=0, Mispredict_Count_o=0.
- BEQ: rs1=rs2=5, pred=0, PC=0x100 -> Branch_Taken_o=1, Mispredict_o=1, Redirect_Sel_o=01. Next cycle, IF_PC_i=0x100 -> Predict_Taken_o=1; both counters=1.
- Signed vs unsigned: rs1=32'hFFFFFFFF, rs2=1 -> BLT taken, BGE not taken, BLTU not taken, BGEU taken.
- Saturation and aliasing:
  - 4 taken updates at PC 0x100 -> state 11; one not-taken -> 10, still predicts 1.
  - Lookup at 0x100 + 4*BHT_ENTRIES -> same prediction.
  - Three further not-taken updates -> 00; a further not-taken stays at 00.
- Stall: valid BNE (taken, pred=0) with EX_Stall_i=1 for 3 cycles -> outputs 0, no BHT or counter change. Stall released -> exactly one update, Mispredict_Count_o +1.
- Illegal and clear:
  - funct3=010, pred=1 -> Illegal_Branch_o=1, Mispredict_o=1, Redirect_Sel_o=10, BHT unchanged, Branch_Count_o unchanged.
  - Clear_Counters_i=1 in the same cycle as a mispredict -> both counters read 0 next cycle.
